simon_control: RTL
==================

Name: simon_control

Overview:
Sequencing FSM for the Simon datapath. It drives the phase code (mode_leds), the read-address mux select, the memory write strobe and the index advance/clear strobes, using the datapath's status flags. It sits between the board's submit button and the datapath. It also paces playback so that each stored pattern stays visible for a fixed number of cycles.

Parameters:
STEP_CYCLES, 4, cycles each element is shown in PLAYBACK and DONE (legal range 1 to 2^CNT_W).
CNT_W, 8, width of the dwell counter.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  reset; synchronous, active-high
submit  input  1  button level, already synchronous to clk
is_legal  input  1  datapath: the current pattern switches form a legal entry
mem_full  input  1  datapath: pattern memory holds 64 entries
seq_end  input  1  datapath: the active read index equals the last stored entry
input_eq_pattern  input  1  datapath: the switch pattern equals the memory read data
mode_leds  output  3  phase code: INPUT=001, PLAYBACK=010, REPEAT=100, DONE=111
select  output  2  read-address mux: 00 playback index, 01 repeat index, 10 done index
w_en  output  1  one-cycle memory write strobe (write to the count address, then increment count)
adv  output  1  one-cycle strobe: increment the index selected by select
clr_idx  output  1  one-cycle strobe: clear the playback, repeat and done indices
lose  output  1  sticky flag: the player mismatched

Behaviour:
- Registers:
  - state, whose encoding equals mode_leds.
  - dwell[CNT_W-1:0].
  - sub_q, the previous value of submit.
  - lose.
- Press detection:
  - press = submit & ~sub_q.
  - sub_q resets to 1, so a button held through reset does not produce a press.
- Output timing:
  - mode_leds, select and lose are registered outputs.
  - w_en, adv and clr_idx are combinational from state, dwell, press and the status inputs.
  - All three strobes are 0 whenever rst=1.
- Reset (any cycle, including mid-phase): state=INPUT (001), select=00, dwell=0, lose=0, sub_q=1, all strobes 0.
- select by state: INPUT 00, PLAYBACK 00, REPEAT 01, DONE 10.
- INPUT:
  - press & is_legal & !mem_full: w_en=1, clr_idx=1, next state PLAYBACK, dwell<=0.
  - press & is_legal & mem_full: clr_idx=1, next state PLAYBACK, no write.
  - press & !is_legal: no strobes, stay in INPUT.
  - No press: hold.
- PLAYBACK:
  - dwell increments each cycle.
  - At dwell==STEP_CYCLES-1 with seq_end=1: clr_idx=1, next state REPEAT, dwell<=0.
  - At dwell==STEP_CYCLES-1 with seq_end=0: adv=1, dwell<=0.
  - Presses are ignored.
- REPEAT (waits for presses; dwell is held at 0):
  - press & input_eq_pattern & seq_end: clr_idx=1, next state INPUT.
  - press & input_eq_pattern & !seq_end: adv=1.
  - press & !input_eq_pattern: clr_idx=1, next state DONE, lose<=1.
- DONE:
  - Same dwell pacing as PLAYBACK.
  - At the end of a step with seq_end=1: clr_idx=1 (wrap to the first entry), stay in DONE.
  - At the end of a step with seq_end=0: adv=1.
  - Presses are ignored; only rst exits DONE.
- Only one strobe group fires per cycle. A press that arrives in the same cycle as a dwell expiry has no effect, because presses are ignored in PLAYBACK and DONE.
- STEP_CYCLES=1: adv or clr_idx fires every cycle in PLAYBACK and DONE.
- Dwell compare uses the CNT_W-bit unsigned value; dwell never exceeds STEP_CYCLES-1.
- lose stays 1 until rst, even across DONE wrap-arounds.

Test Plan:
1. Reset held with submit=1, then release with submit held for 3 cycles -> mode_leds=001, no w_en, lose=0 throughout.
2. INPUT: is_legal=1, one press -> w_en=1 and clr_idx=1 in the press cycle; next cycle mode_leds=010, select=00.
3. PLAYBACK, STEP_CYCLES=4, seq_end forced high on the 2nd step -> adv on cycle 4, clr_idx on cycle 8, then mode_leds=100, select=01.
4. REPEAT: matched press with seq_end=0 -> adv=1; matched press with seq_end=1 -> clr_idx=1, then mode_leds=001. Illegal press back in INPUT -> no strobe, stays 001.
5. REPEAT: mismatched press -> clr_idx=1; next cycle mode_leds=111, select=10, lose=1. DONE wraps (clr_idx) each time seq_end=1 at dwell expiry; lose persists.
6. rst asserted mid-PLAYBACK at dwell=2 -> next cycle mode_leds=001, dwell=0, lose=0, no strobes in the reset cycle. mem_full=1 with a legal press -> PLAYBACK entered with w_en=0.

Source files
------------

// File: rtl/simon_control.sv
// Sequencing FSM for the Simon datapath: phase code, read-mux select, write/advance/clear
// strobes, and dwell pacing so each pattern stays visible for STEP_CYCLES cycles.
module simon_control #(
  parameter int STEP_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       submit,
  input  logic       is_legal,
  input  logic       mem_full,
  input  logic       seq_end,
  input  logic       input_eq_pattern,
  output logic [2:0] mode_leds,
  output logic [1:0] select,
  output logic       w_en,
  output logic       adv,
  output logic       clr_idx,
  output logic       lose
);

  localparam logic [2:0] S_INPUT    = 3'b001;
  localparam logic [2:0] S_PLAYBACK = 3'b010;
  localparam logic [2:0] S_REPEAT   = 3'b100;
  localparam logic [2:0] S_DONE     = 3'b111;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(STEP_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       select_q, select_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             sub_q, sub_d;
  logic             lose_q, lose_d;
  logic             press, expire;
  logic             w_en_c, adv_c, clr_c;

  assign press  = submit & ~sub_q;
  assign expire = (dwell_q == DWELL_LAST);

  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    lose_d   = lose_q;
    sub_d    = submit;
    w_en_c   = 1'b0;
    adv_c    = 1'b0;
    clr_c    = 1'b0;
    select_d = 2'b00;
    unique case (state_q)
      S_INPUT: begin
        dwell_d = '0;
        if (press && is_legal) begin
          clr_c   = 1'b1;
          w_en_c  = ~mem_full;
          state_d = S_PLAYBACK;
        end
      end
      S_PLAYBACK, S_DONE: begin
        // DONE shares the pacing; it wraps to the first entry instead of moving on
        if (expire) begin
          dwell_d = '0;
          if (seq_end) begin
            clr_c = 1'b1;
            if (state_q == S_PLAYBACK) state_d = S_REPEAT;
          end else begin
            adv_c = 1'b1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      S_REPEAT: begin
        dwell_d = '0;
        if (press) begin
          if (!input_eq_pattern) begin
            clr_c   = 1'b1;
            lose_d  = 1'b1;
            state_d = S_DONE;
          end else if (seq_end) begin
            clr_c   = 1'b1;
            state_d = S_INPUT;
          end else begin
            adv_c = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_INPUT;
        dwell_d = '0;
      end
    endcase
    unique case (state_d)
      S_REPEAT: select_d = 2'b01;
      S_DONE:   select_d = 2'b10;
      default:  select_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_INPUT;
      select_q <= 2'b00;
      dwell_q  <= '0;
      sub_q    <= 1'b1;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      dwell_q  <= dwell_d;
      sub_q    <= sub_d;
      lose_q   <= lose_d;
    end
  end

  assign mode_leds = state_q;
  assign select    = select_q;
  assign lose      = lose_q;
  assign w_en      = w_en_c & ~rst;
  assign adv       = adv_c & ~rst;
  assign clr_idx   = clr_c & ~rst;

endmodule
